// File: rtl/fpu_mul_writeback.sv
// rtl/fpu_mul_writeback.sv - multiplier writeback FIFO with result classification, sticky status (FPU_WB_STICKY_EN) and result counter
module fpu_mul_writeback #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_overflow,
    input  logic             in_underflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [3:0]       out_flags,
    input  logic             clear_flags,
    output logic [3:0]       sticky_flags,
    output logic [CNT_W-1:0] result_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Each entry is {flags[3:0], result[31:0]}
    logic [35:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [3:0]       push_flags;
    logic [3:0]       pushed_flags;

    // Handshake status comes from registered occupancy only
    assign full      = (occ == OCC_W'(DEPTH));
    assign empty     = (occ == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Classification of the incoming word: {inf, zero, underflow, overflow}
    assign push_flags   = {(in_result[30:23] == 8'hFF), (in_result[30:0] == 31'd0),
                           in_underflow, in_overflow};
    assign pushed_flags = push ? push_flags : 4'b0000;

    // Circular buffer storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_flags, in_result};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Head entry is presented directly from storage
    assign {out_flags, out_data} = mem[rd_ptr];

    // Count of accepted entries, wrapping naturally at the counter width
    always_ff @(posedge clk) begin
        if (rst) begin
            result_count <= '0;
        end else if (push) begin
            result_count <= result_count + CNT_W'(1);
        end
    end

`ifdef FPU_WB_STICKY_EN
    // Sticky status; a push coinciding with a clear still leaves its flags set
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_flags <= 4'b0000;
        end else if (clear_flags) begin
            sticky_flags <= pushed_flags;
        end else begin
            sticky_flags <= sticky_flags | pushed_flags;
        end
    end
`else
    logic       unused_clear;
    logic [3:0] unused_pushed;
    assign unused_clear  = clear_flags;
    assign unused_pushed = pushed_flags;
    assign sticky_flags  = 4'b0000;
`endif

endmodule

// File: tb/tb_fpu_mul_writeback.sv
// tb/tb_fpu_mul_writeback.sv - randomized and directed self-checking bench for fpu_mul_writeback
module tb_fpu_mul_writeback;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        in_underflow;
    logic        out_ready;
    logic        clear_flags;

    logic        in_ready,  out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_flags, sticky_flags;
    logic [15:0] result_count;

    logic        in_ready4, out_valid4;
    logic [31:0] out_data4;
    logic [3:0]  out_flags4, sticky_flags4;
    logic [3:0]  result_count4;

    fpu_mul_writeback #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_overflow(in_overflow), .in_underflow(in_underflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .clear_flags(clear_flags),
        .sticky_flags(sticky_flags), .result_count(result_count)
    );

    fpu_mul_writeback #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_result(in_result), .in_overflow(in_overflow), .in_underflow(in_underflow),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_flags(out_flags4), .clear_flags(clear_flags),
        .sticky_flags(sticky_flags4), .result_count(result_count4)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [35:0] q[$];
    logic [3:0]  m_sticky;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [3:0] ref_flags(input logic [31:0] r, input logic o, input logic u);
        logic is_inf, is_zero;
        is_inf  = ((r >> 23) & 32'hFF) == 32'hFF;
        is_zero = (r & 32'h7FFF_FFFF) == 32'd0;
        return {is_inf, is_zero, u, o};
    endfunction

    function automatic logic [3:0] sticky_exp(input logic [3:0] v);
`ifdef FPU_WB_STICKY_EN
        return v;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic step();
        logic do_push, do_pop;
        logic [3:0] pf;
        @(negedge clk);
        check("in_ready",   {31'd0, in_ready},  {31'd0, q.size() < DEPTH});
        check("out_valid",  {31'd0, out_valid}, {31'd0, q.size() > 0});
        check("in_ready4",  {31'd0, in_ready4}, {31'd0, q.size() < DEPTH});
        if (q.size() > 0) begin
            check("out_data",  out_data,           q[0][31:0]);
            check("out_flags", {28'd0, out_flags}, {28'd0, q[0][35:32]});
            check("out_data4", out_data4,          q[0][31:0]);
        end
        check("sticky",  {28'd0, sticky_flags},  {28'd0, sticky_exp(m_sticky)});
        check("count",   {16'd0, result_count},  m_cnt % 65536);
        check("count4",  {28'd0, result_count4}, m_cnt % 16);
        do_push = in_valid && (q.size() < DEPTH);
        do_pop  = out_ready && (q.size() > 0);
        pf      = ref_flags(in_result, in_overflow, in_underflow);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_sticky = 4'b0000;
            m_cnt    = 0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back({pf, in_result});
                m_cnt++;
            end
            if (!do_push) pf = 4'b0000;
            m_sticky = clear_flags ? pf : (m_sticky | pf);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic o, input logic u, input logic rdy);
        in_valid = v; in_result = r; in_overflow = o; in_underflow = u; out_ready = rdy;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7F80_0000;
            3: return 32'hFF80_0000;
            4: return 32'h7FC0_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] seq [5];
        rst = 1'b1; clear_flags = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        q.delete(); m_sticky = 4'b0000; m_cnt = 0;
        step();
        rst = 1'b0;
        check("rst_out_data",  out_data, 32'h0);
        check("rst_out_flags", {28'd0, out_flags}, 32'h0);

        // Single push
        drive(1'b1, 32'h40C0_0000, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_data",  out_data, 32'h40C0_0000);
        check("single_flags", {28'd0, out_flags}, 32'h0);
        check("single_count", {16'd0, result_count}, 32'd1);
        step();

        // Five pushes into a four-deep FIFO with the consumer stalled
        seq = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, seq[k], 1'b0, 1'b0, 1'b0);
            step();
        end
        check("full_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, seq[4], 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, seq[4], 1'b0, 1'b0, 1'b1);
        step();
        check("full_after_pop", {31'd0, in_ready}, 32'd1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step();
        check("drain_count", {16'd0, result_count}, 32'd6);

        // Classification and sticky status
        drive(1'b1, 32'h7F80_0000, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("inf_flags",   {28'd0, out_flags},    32'h9);
        check("sticky_both", {28'd0, sticky_flags}, {28'd0, sticky_exp(4'b1111)});
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        check("zero_flags",  {28'd0, out_flags},    32'h6);
        step();

        // Clear coinciding with a push of zero
        clear_flags = 1'b1;
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        step();
        clear_flags = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("clear_push", {28'd0, sticky_flags}, {28'd0, sticky_exp(4'b0100)});
        step();

        // Reset with three entries queued and sticky set
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hFF80_0000, 1'b1, 1'b1, 1'b0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rst_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_ready",  {31'd0, in_ready},  32'd1);
        check("rst_sticky", {28'd0, sticky_flags}, 32'd0);
        check("rst_count",  {16'd0, result_count}, 32'd0);

        // Seventeen pushes with continuous pop; narrow counter wraps
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("wrap_count4", {28'd0, result_count4}, 32'd1);
        check("wrap_count",  {16'd0, result_count},  32'd17);
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, rand_word(), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2) != 0);
            clear_flags = ($urandom_range(0, 9) == 0);
            rst         = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 1'b0; clear_flags = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
